// File: rtl/blowfish_req_arbiter.sv
// Round-robin arbiter feeding two requesters into Blowfish enc/dec cores.
// One job in flight; per-wait-state timeout yields an error response.
//
// Ports:
//   clk, reset          clock, async active-low reset
//   reqN_valid/decrypt  request N pending, 1 = decrypt
//   reqN_data           64-bit block for request N
//   reqN_ready          one-cycle accept pulse
//   resp_valid/id       one-cycle result pulse, requester index
//   resp_data/error     result block, timeout flag (held until next result)
//   enc_*/dec_*         core plain bus, start pulse, busy/init, cipher
//   abort_blowfish      abort pulse to the decrypt core on timeout
module blowfish_req_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic        req1_valid,
  input  logic        req0_decrypt,
  input  logic        req1_decrypt,
  input  logic [63:0] req0_data,
  input  logic [63:0] req1_data,
  output logic        req0_ready,
  output logic        req1_ready,
  output logic        resp_valid,
  output logic        resp_id,
  output logic [63:0] resp_data,
  output logic        resp_error,
  output logic [63:0] enc_plain,
  output logic [63:0] dec_plain,
  output logic        enc_start,
  output logic        dec_start,
  input  logic        enc_busy,
  input  logic        dec_busy,
  input  logic        enc_init,
  input  logic        dec_init,
  input  logic [63:0] enc_cipher,
  input  logic [63:0] dec_cipher,
  output logic        abort_blowfish
);

  localparam int CW =
    (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    RESP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic [63:0]   job_data_q;
  logic          job_dec_q;
  logic          job_id_q;
  logic          last_grant_q;
  logic [63:0]   resp_data_q;
  logic          resp_id_q;
  logic          resp_err_q;

  logic elig0, elig1;
  logic grant_id;
  logic take;
  logic fin, fin_err;
  logic sel_busy;
  logic [63:0] sel_cipher;
  logic timed_out;

  // A decrypt needs the encrypt core idle too:
  // both cores share the key schedule.
  assign elig0 = req0_valid && !enc_init
              && (!req0_decrypt || !dec_init);
  assign elig1 = req1_valid && !enc_init
              && (!req1_decrypt || !dec_init);

  always_comb begin
    grant_id = 1'b0;
    unique case (1'b1)
      elig0 && elig1:  grant_id = !last_grant_q;
      elig1 && !elig0: grant_id = 1'b1;
      default:         grant_id = 1'b0;
    endcase
  end

  assign sel_busy   = job_dec_q ? dec_busy : enc_busy;
  assign sel_cipher = job_dec_q ? dec_cipher
                                : enc_cipher;

  assign cnt_inc   = (cnt_q == '1) ? cnt_q
                                   : cnt_q + 1'b1;
  assign timed_out = (cnt_inc >= CW'(TIMEOUT));

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req0_ready     = 1'b0;
    req1_ready     = 1'b0;
    enc_start      = 1'b0;
    dec_start      = 1'b0;
    abort_blowfish = 1'b0;
    take           = 1'b0;
    fin            = 1'b0;
    fin_err        = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          take       = 1'b1;
          req0_ready = !grant_id;
          req1_ready = grant_id;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        enc_start = !job_dec_q;
        dec_start = job_dec_q;
        cnt_d     = '0;
        state_d   = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (sel_busy) begin
          cnt_d   = '0;
          state_d = WAIT_DONE;
        end else if (timed_out) begin
          fin            = 1'b1;
          fin_err        = 1'b1;
          abort_blowfish = job_dec_q;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_DONE: begin
        if (!sel_busy) begin
          fin     = 1'b1;
          state_d = RESP;
        end else if (timed_out) begin
          fin            = 1'b1;
          fin_err        = 1'b1;
          abort_blowfish = job_dec_q;
          state_d        = RESP;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      job_data_q   <= '0;
      job_dec_q    <= 1'b0;
      job_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
      resp_data_q  <= '0;
      resp_id_q    <= 1'b0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (take) begin
        job_data_q   <= grant_id ? req1_data
                                 : req0_data;
        job_dec_q    <= grant_id ? req1_decrypt
                                 : req0_decrypt;
        job_id_q     <= grant_id;
        last_grant_q <= grant_id;
      end
      if (fin) begin
        resp_data_q <= fin_err ? '0 : sel_cipher;
        resp_err_q  <= fin_err;
        resp_id_q   <= job_id_q;
      end
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign resp_error = resp_err_q;

  assign enc_plain =
    (state_q != IDLE && !job_dec_q) ? job_data_q
                                    : '0;
  assign dec_plain =
    (state_q != IDLE && job_dec_q) ? job_data_q
                                   : '0;

endmodule

// File: tb/tb_blowfish_req_arbiter.sv
// Bench for blowfish_req_arbiter with behavioural enc/dec cores.
// Two instances: default TIMEOUT and TIMEOUT=8.
module tb_blowfish_req_arbiter;

  typedef struct packed {
    logic        id;
    logic        err;
    logic [63:0] data;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        req0_valid, req1_valid;
  logic        req0_decrypt, req1_decrypt;
  logic [63:0] req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        resp_valid, resp_id, resp_error;
  logic [63:0] resp_data;
  logic [63:0] enc_plain, dec_plain;
  logic        enc_start, dec_start;
  logic        enc_busy, dec_busy;
  logic        enc_init, dec_init;
  logic [63:0] enc_cipher, dec_cipher;
  logic        abort_blowfish;

  logic        t_req0_ready, t_req1_ready;
  logic        t_resp_valid, t_resp_id, t_resp_error;
  logic [63:0] t_resp_data;
  logic [63:0] t_enc_plain, t_dec_plain;
  logic        t_enc_start, t_dec_start;
  logic        t_abort;

  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];
  exp_t got, t_got;

  int enc_len = 3;
  int dec_len = 4;
  bit dec_stall = 0;
  int ecnt, dcnt;

  assign got   = {resp_id, resp_error, resp_data};
  assign t_got = {t_resp_id, t_resp_error,
                  t_resp_data};

  blowfish_req_arbiter dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_decrypt(req0_decrypt),
    .req1_decrypt(req1_decrypt),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(req0_ready),
    .req1_ready(req1_ready),
    .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_data(resp_data),
    .resp_error(resp_error),
    .enc_plain(enc_plain), .dec_plain(dec_plain),
    .enc_start(enc_start), .dec_start(dec_start),
    .enc_busy(enc_busy), .dec_busy(dec_busy),
    .enc_init(enc_init), .dec_init(dec_init),
    .enc_cipher(enc_cipher),
    .dec_cipher(dec_cipher),
    .abort_blowfish(abort_blowfish)
  );

  blowfish_req_arbiter #(.TIMEOUT(8)) dut_t (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid),
    .req1_valid(req1_valid),
    .req0_decrypt(req0_decrypt),
    .req1_decrypt(req1_decrypt),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_ready(t_req0_ready),
    .req1_ready(t_req1_ready),
    .resp_valid(t_resp_valid),
    .resp_id(t_resp_id),
    .resp_data(t_resp_data),
    .resp_error(t_resp_error),
    .enc_plain(t_enc_plain),
    .dec_plain(t_dec_plain),
    .enc_start(t_enc_start),
    .dec_start(t_dec_start),
    .enc_busy(enc_busy), .dec_busy(dec_busy),
    .enc_init(enc_init), .dec_init(dec_init),
    .enc_cipher(enc_cipher),
    .dec_cipher(dec_cipher),
    .abort_blowfish(t_abort)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] xform(
    input bit dec, input logic [63:0] d);
    return dec ? {d[31:0], d[63:32]} : ~d;
  endfunction

  // Behavioural cores: busy rises the cycle after start,
  // stays high for N cycles, cipher valid from start.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      enc_busy   <= 1'b0;
      ecnt       <= 0;
      enc_cipher <= '0;
    end else if (enc_start) begin
      enc_busy   <= 1'b1;
      ecnt       <= enc_len;
      enc_cipher <= xform(1'b0, enc_plain);
    end else if (enc_busy) begin
      if (ecnt <= 1) enc_busy <= 1'b0;
      ecnt <= ecnt - 1;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      dec_busy   <= 1'b0;
      dcnt       <= 0;
      dec_cipher <= '0;
    end else if (dec_start && !dec_stall) begin
      dec_busy   <= 1'b1;
      dcnt       <= dec_len;
      dec_cipher <= xform(1'b1, dec_plain);
    end else if (dec_busy) begin
      if (dcnt <= 1) dec_busy <= 1'b0;
      dcnt <= dcnt - 1;
    end
  end

  task automatic wait_ready(input int max,
                            output bit ok,
                            output bit id);
    ok = 0;
    id = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        ok = 1;
        id = req1_ready;
        return;
      end
    end
  endtask

  task automatic wait_resp(input int max,
                           output bit ok,
                           output int n);
    ok = 0;
    n = 0;
    for (int i = 1; i <= max; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        ok = 1;
        n = i;
        return;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      failures++;
      $display("FAIL rst_ready got=%b exp=00",
               {req0_ready, req1_ready});
    end
    checks++;
    if ({resp_valid, got} !== '0) begin
      failures++;
      $display("FAIL rst_resp got=%b/%h exp=0/0",
               resp_valid, got);
    end
    checks++;
    if ({enc_start, dec_start, abort_blowfish,
         enc_plain, dec_plain} !== '0) begin
      failures++;
      $display("FAIL rst_core got st=%b%b ab=%b %h %h exp=0",
               enc_start, dec_start, abort_blowfish,
               enc_plain, dec_plain);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({resp_valid, enc_start, dec_start} !== 3'b000)
    begin
      failures++;
      $display("FAIL rst_idle got=%b exp=000",
               {resp_valid, enc_start, dec_start});
    end
  endtask

  task automatic test_tie();
    bit ok, id, early, seen;
    int n;
    exp_t e;
    @(posedge clk); #1;
    req0_valid = 1; req0_decrypt = 0;
    req0_data = 64'h1111_2222_3333_4444;
    req1_valid = 1; req1_decrypt = 0;
    req1_data = 64'hAAAA_BBBB_CCCC_DDDD;
    wait_ready(5, ok, id);
    checks++;
    if (!ok || id !== 1'b0) begin
      failures++;
      $display("FAIL tie_first got ok=%0d id=%0d exp id=0",
               ok, id);
    end
    sb.push_back({id, 1'b0,
                  xform(0, id ? req1_data : req0_data)});
    @(posedge clk); #1;
    if (id) req1_valid = 0; else req0_valid = 0;
    early = 0;
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (req1_ready) early = 1;
      if (resp_valid) begin
        seen = 1;
        checks++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
        if (got !== e) begin
          failures++;
          $display("FAIL tie_resp0 got=%h exp=%h", got, e);
        end
      end
    end
    checks++;
    if (!seen || early) begin
      failures++;
      $display("FAIL tie_order got resp=%0d early=%0d exp 1/0",
               seen, early);
    end
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL tie_second got=%b exp=1", req1_ready);
    end
    sb.push_back({1'b1, 1'b0, xform(0, req1_data)});
    @(posedge clk); #1;
    req1_valid = 0;
    wait_resp(30, ok, n);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL tie_resp1 got=none exp=response");
    end else begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = '1;
      if (got !== e) begin
        failures++;
        $display("FAIL tie_resp1 got=%h exp=%h", got, e);
      end
    end
  endtask

  task automatic test_latency();
    bit ok, id;
    int n;
    exp_t e;
    enc_len = 16;
    @(posedge clk); #1;
    req0_valid = 1; req0_decrypt = 0;
    req0_data = 64'h0123_4567_89AB_CDEF;
    wait_ready(5, ok, id);
    checks++;
    if (!ok || id !== 1'b0) begin
      failures++;
      $display("FAIL lat_accept got ok=%0d id=%0d exp 1/0",
               ok, id);
    end
    sb.push_back({1'b0, 1'b0, 64'hFEDC_BA98_7654_3210});
    @(posedge clk); #1;
    req0_valid = 0;
    @(negedge clk);
    checks++;
    if ({enc_start, dec_start, enc_plain, dec_plain} !==
        {2'b10, 64'h0123_4567_89AB_CDEF, 64'h0}) begin
      failures++;
      $display("FAIL lat_start got st=%b%b %h %h exp=10 0123456789abcdef 0",
               enc_start, dec_start, enc_plain, dec_plain);
    end
    wait_resp(40, ok, n);
    checks++;
    if (!ok || n + 1 != 19) begin
      failures++;
      $display("FAIL lat_cycles got=%0d exp=19", n + 1);
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL lat_resp got=none exp=response");
    end else begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = '1;
      if (got !== e) begin
        failures++;
        $display("FAIL lat_resp got=%h exp=%h", got, e);
      end
    end
    @(negedge clk);
    checks++;
    if ({resp_valid, resp_data} !==
        {1'b0, 64'hFEDC_BA98_7654_3210}) begin
      failures++;
      $display("FAIL lat_hold got=%b/%h exp=0/fedcba9876543210",
               resp_valid, resp_data);
    end
    enc_len = 3;
  endtask

  task automatic test_init_gate();
    bit ok, saw;
    int n;
    exp_t e;
    @(posedge clk); #1;
    enc_init = 1;
    req1_valid = 1; req1_decrypt = 1;
    req1_data = 64'hDEAD_BEEF_0BAD_F00D;
    saw = 0;
    repeat (6) begin
      @(negedge clk);
      if (req1_ready) saw = 1;
    end
    checks++;
    if (saw) begin
      failures++;
      $display("FAIL gate_block got ready=1 exp=0");
    end
    @(posedge clk); #1;
    enc_init = 0;
    @(negedge clk);
    checks++;
    if (req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL gate_grant got=%b exp=1", req1_ready);
    end
    sb.push_back({1'b1, 1'b0, xform(1, req1_data)});
    @(posedge clk); #1;
    req1_valid = 0;
    enc_init = 1;
    wait_resp(30, ok, n);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL gate_resp got=none exp=response");
    end else begin
      if (sb.size() != 0) e = sb.pop_front();
      else e = '1;
      if (got !== e) begin
        failures++;
        $display("FAIL gate_resp got=%h exp=%h", got, e);
      end
    end
    enc_init = 0;
  endtask

  task automatic test_fairness();
    bit ok, id;
    int n;
    exp_t e;
    logic [2:0] grants;
    grants = '1;
    @(posedge clk); #1;
    req0_valid = 1; req0_decrypt = 0;
    req0_data = 64'h0F0F_0F0F_1234_5678;
    req1_valid = 1; req1_decrypt = 0;
    req1_data = 64'h5555_AAAA_9999_6666;
    for (int j = 0; j < 3; j++) begin
      wait_ready(10, ok, id);
      if (!ok) break;
      grants[2-j] = id;
      sb.push_back({id, 1'b0,
                    xform(0, id ? req1_data : req0_data)});
      @(posedge clk); #1;
      if (id) req1_valid = 0;
      if (j == 2) req0_valid = 0;
      wait_resp(30, ok, n);
      checks++;
      if (!ok) begin
        failures++;
        $display("FAIL fair_resp%0d got=none exp=response", j);
        break;
      end
      if (sb.size() != 0) e = sb.pop_front();
      else e = '1;
      if (got !== e) begin
        failures++;
        $display("FAIL fair_resp%0d got=%h exp=%h",
                 j, got, e);
      end
    end
    req0_valid = 0;
    req1_valid = 0;
    checks++;
    if (grants !== 3'b010) begin
      failures++;
      $display("FAIL fair_order got=%b exp=010", grants);
    end
  endtask

  task automatic test_reset_mid_job();
    bit ok, id, seen;
    enc_len = 10;
    @(posedge clk); #1;
    req0_valid = 1; req0_decrypt = 0;
    req0_data = 64'h7777_8888_9999_AAAA;
    wait_ready(5, ok, id);
    @(posedge clk); #1;
    req0_valid = 0;
    repeat (4) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({resp_valid, got, enc_start, enc_plain} !== '0)
    begin
      failures++;
      $display("FAIL rstjob_zero got v=%b %h st=%b pl=%h exp=0",
               resp_valid, got, enc_start, enc_plain);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (resp_valid) seen = 1;
    end
    checks++;
    if (seen || !ok) begin
      failures++;
      $display("FAIL rstjob_noresp got resp=%0d acc=%0d exp 0/1",
               seen, ok);
    end
    enc_len = 3;
  endtask

  task automatic test_timeout();
    bit ok;
    int aborts, ab_at, rs_at;
    exp_t e;
    dec_stall = 1;
    @(posedge clk); #1;
    req0_valid = 1; req0_decrypt = 1;
    req0_data = 64'hCAFE_BABE_1357_9BDF;
    ok = 0;
    for (int i = 0; i < 5 && !ok; i++) begin
      @(negedge clk);
      if (t_req0_ready) ok = 1;
    end
    sb.push_back({1'b0, 1'b1, 64'h0});
    @(posedge clk); #1;
    req0_valid = 0;
    aborts = 0; ab_at = 0; rs_at = 0;
    for (int i = 1; i <= 25 && rs_at == 0; i++) begin
      @(negedge clk);
      if (t_abort) begin
        aborts++;
        ab_at = i;
      end
      if (t_resp_valid) begin
        rs_at = i;
        checks++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '1;
        if (t_got !== e) begin
          failures++;
          $display("FAIL tmo_resp got=%h exp=%h", t_got, e);
        end
      end
    end
    checks++;
    if (!ok || aborts != 1 || ab_at < 9 || ab_at > 10
        || rs_at != ab_at + 1) begin
      failures++;
      $display("FAIL tmo_abort got acc=%0d n=%0d at=%0d resp=%0d exp 1/1/9..10/at+1",
               ok, aborts, ab_at, rs_at);
    end
    @(posedge clk); #1;
    req1_valid = 1; req1_decrypt = 0;
    @(negedge clk);
    checks++;
    if (t_req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL tmo_idle got=%b exp=1", t_req1_ready);
    end
    @(posedge clk); #1;
    req1_valid = 0;
    dec_stall = 0;
  endtask

  initial begin
    reset = 0;
    req0_valid = 0; req1_valid = 0;
    req0_decrypt = 0; req1_decrypt = 0;
    req0_data = '0; req1_data = '0;
    enc_init = 0; dec_init = 0;
    test_reset();
    test_tie();
    test_latency();
    test_init_gate();
    test_fairness();
    test_reset_mid_job();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
